core_18: RTL and testbench
==========================

CORE_18 -- requirements
Module: core_18

Interface
REQ-001 Parameters: none.
REQ-002 CLK  in  1  rising-edge clock; only clock.
REQ-003 RUN  in  1  run enable; reset is synchronous and active-high, with reset = NOT RUN, sampled at CLK rise.
REQ-004 RESET  out  1  = NOT RUN (combinational), exported active-high synchronous reset.
REQ-005 INST  in  18  instruction word at address PC (combinational program ROM).
REQ-006 VECTOR  in  4  interrupt request number; 0 = none.
REQ-007 DATAIN  in  18  read data from RAM, port or constant space.
REQ-008 BITSIN  in  64  external flag bits.
REQ-009 BITSOUT  out  64  flag-bit register.
REQ-010 CONST_RD, PORT_RD, PORT_WR, RAM_WR  out  1 each  one-cycle registered strobes.
REQ-011 DATAOUT  out  18  registered write data.
REQ-012 ADRS  out  18  registered address; holds last value when idle.
REQ-013 PC  out  12  program counter.

Function
REQ-014 State SHALL be one-hot, 10 bits: EXEC 0o0001, INIT 0o0002, LD1 0o0004, LD2 0o0010, STOP 0o0020, RTI1 0o0040, RTI2 0o0100, INT 0o1000; bits 7-8 unused.
REQ-015 Internal registers: A (18), SP (18), level (4), flags Z and F.
REQ-016 INIT SHALL go to EXEC after one clock, with PC unchanged.
REQ-017 EXEC SHALL execute INST in one clock and set PC <= PC+1 (12-bit wrap) unless a jump or interrupt occurs.
REQ-018 Opcode field INST[17:15]: 0 system; 1 JMP; 2 branch; 3 CALL; 4 BIT; 5 LDI; 6 ALU; 7 MEM.
REQ-019 System group, sub-op INST[8:6]:
- 0 NOP.
- 1 STOP: PC+1, then state STOP.
- 4 RTI.
- 5 LEVEL: level <= INST[3:0].
- Other sub-ops act as NOP.
REQ-020 JMP: PC <= INST[11:0]. Branch: if (INST[14] ? F : Z) then PC <= INST[11:0], else PC+1.
REQ-021 CALL: push {Z,F,level,PC+1} as for an interrupt; PC <= INST[11:0]; return is by RTI.
REQ-022 BIT: n = INST[5:0]; INST[7:6] selects:
- 0 clear BITSOUT[n].
- 1 set BITSOUT[n].
- 2 F <= BITSOUT[n].
- 3 F <= BITSIN[n].
REQ-023 LDI: A <= zero-extended INST[14:0].
REQ-024 ALU: A <= A op zero-extended INST[11:0], modulo 2^18. INST[14:12] selects ADD, SUB, AND, OR, XOR; codes 5-7 act as NOP.
REQ-025 Z SHALL be set to (result == 0) on every write to A.
REQ-026 MEM: address = zero-extended INST[11:0]; INST[14:12] selects:
- 0 RAM load.
- 1 RAM store (DATAOUT <= A, RAM_WR).
- 2 port read (PORT_RD).
- 3 port write (DATAOUT <= A, PORT_WR).
- 4 constant read (CONST_RD).
- 5-7 act as NOP.
REQ-027 Each strobe and ADRS/DATAOUT SHALL be valid in the cycle after the issuing clock.
REQ-028 Loads SHALL proceed EXEC -> LD1 -> LD2 -> EXEC, capturing DATAIN into A at the LD2 clock.
REQ-029 Stack word format: [17]=Z, [16]=F, [15:12]=level, [11:0]=PC. Push pre-decrements SP; pop post-increments SP.
REQ-030 Interrupt SHALL be accepted only in EXEC or STOP, when VECTOR != 0 and VECTOR > level. INST is not executed.
REQ-031 On interrupt acceptance: save {Z,F,level,PC} with PC not incremented; level <= VECTOR; state <= INT.
REQ-032 INT SHALL take one clock: SP <= SP-1; ADRS <= SP-1; DATAOUT <= saved word; RAM_WR pulse; PC <= zero-extended VECTOR (as latched at acceptance); state <= EXEC.
REQ-033 RTI in EXEC: ADRS <= SP, SP <= SP+1, then RTI1 -> RTI2.
REQ-034 At the RTI2 clock: PC <= DATAIN[11:0], level <= DATAIN[15:12], F <= DATAIN[16], Z <= DATAIN[17]; state <= EXEC.
REQ-035 STOP SHALL hold PC and all registers until an interrupt is accepted.
REQ-036 VECTOR SHALL be ignored in INIT, LD1, LD2, RTI1, RTI2 and INT.

Reset
REQ-037 While RESET=1 at a CLK rise, reset SHALL override all activity, including mid-load, mid-RTI and INT.
REQ-038 Reset values: PC=0, state=INIT, level=15, Z=F=0, A=0, SP=0, ADRS=0, DATAOUT=0, BITSOUT=0, all strobes 0.

Verification
REQ-039 Reset and LEVEL: reset, RUN=1, INST=0o000505 -> level 15 after clock 1 and 5 after clock 2.
REQ-040 STOP: after LEVEL 5 and NOPs at PC 1-2, STOP at PC 3 -> PC=4, state 0o0020. PC and state stay unchanged across 3 further clocks.
REQ-041 Interrupt from STOP: VECTOR=7 for one clock -> level 7, state 0o1000. Next clock:
- state 0o0001, PC=7.
- ADRS=0o777777, DATAOUT=0o050004, RAM_WR=1.
- After a following NOP: ADRS still 0o777777.
REQ-042 RTI: INST=0o000400 -> states 0o0040, then 0o0100. DATAIN=0o651234 at the next clock -> PC=0o1234, level 5, Z=1, F=1. The following NOP -> PC=0o1235.
REQ-043 Masking: level 5 with VECTOR=5 or VECTOR=3 -> no interrupt accepted.
REQ-044 Loads and flags:
- LDI 0, then ADD 1: Z goes 1 -> 0.
- MEM port read: PORT_RD=1 for exactly one cycle; A=DATAIN captured at LD2.
- BIT set n=63, then test n=63: F=1.

Source files
------------

// File: rtl/core_18.sv
// core_18: small 18-bit accumulator controller with one-hot sequencing,
// flag-bit I/O, a RAM-resident stack for CALL/interrupts, and registered bus strobes.
module core_18 (
  input  logic        CLK,
  input  logic        RUN,
  output logic        RESET,
  input  logic [17:0] INST,
  input  logic [3:0]  VECTOR,
  input  logic [17:0] DATAIN,
  input  logic [63:0] BITSIN,
  output logic [63:0] BITSOUT,
  output logic        CONST_RD,
  output logic        PORT_RD,
  output logic        PORT_WR,
  output logic        RAM_WR,
  output logic [17:0] DATAOUT,
  output logic [17:0] ADRS,
  output logic [11:0] PC
);

  typedef enum logic [9:0] {
    EXEC = 10'o0001,
    INIT = 10'o0002,
    LD1  = 10'o0004,
    LD2  = 10'o0010,
    STOP = 10'o0020,
    RTI1 = 10'o0040,
    RTI2 = 10'o0100,
    INT  = 10'o1000
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [17:0] a_q, a_d, sp_q, sp_d, adrs_q, adrs_d, dout_q, dout_d, sav_q, sav_d;
  logic [3:0]  level_q, level_d, vec_q, vec_d;
  logic        z_q, z_d, f_q, f_d;
  logic [63:0] bits_q, bits_d;
  logic        crd_q, crd_d, prd_q, prd_d, pwr_q, pwr_d, rwr_q, rwr_d;

  logic        irq;
  logic [11:0] pc_inc;
  logic [17:0] imm, alu_r, sp_dec;

  assign RESET    = ~RUN;
  assign PC       = pc_q;
  assign ADRS     = adrs_q;
  assign DATAOUT  = dout_q;
  assign BITSOUT  = bits_q;
  assign CONST_RD = crd_q;
  assign PORT_RD  = prd_q;
  assign PORT_WR  = pwr_q;
  assign RAM_WR   = rwr_q;

  assign irq    = (VECTOR != 4'd0) && (VECTOR > level_q);
  assign pc_inc = pc_q + 12'd1;
  assign imm    = {6'd0, INST[11:0]};
  assign sp_dec = sp_q - 18'd1;

  always_comb begin
    alu_r = a_q;
    case (INST[14:12])
      3'd0:    alu_r = a_q + imm;
      3'd1:    alu_r = a_q - imm;
      3'd2:    alu_r = a_q & imm;
      3'd3:    alu_r = a_q | imm;
      3'd4:    alu_r = a_q ^ imm;
      default: alu_r = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    sp_d    = sp_q;
    adrs_d  = adrs_q;
    dout_d  = dout_q;
    sav_d   = sav_q;
    level_d = level_q;
    vec_d   = vec_q;
    z_d     = z_q;
    f_d     = f_q;
    bits_d  = bits_q;
    crd_d   = 1'b0;
    prd_d   = 1'b0;
    pwr_d   = 1'b0;
    rwr_d   = 1'b0;

    if ((state_q == EXEC || state_q == STOP) && irq) begin
      // The interrupted instruction is not executed, so the saved PC is not advanced.
      sav_d   = {z_q, f_q, level_q, pc_q};
      level_d = VECTOR;
      vec_d   = VECTOR;
      state_d = INT;
    end else begin
      case (state_q)
        INIT: state_d = EXEC;
        EXEC: begin
          pc_d = pc_inc;
          case (INST[17:15])
            3'd0: case (INST[8:6])
              3'd1: state_d = STOP;
              3'd4: begin
                adrs_d  = sp_q;
                sp_d    = sp_q + 18'd1;
                state_d = RTI1;
              end
              3'd5: level_d = INST[3:0];
              default: ;
            endcase
            3'd1: pc_d = INST[11:0];
            3'd2: if (INST[14] ? f_q : z_q) pc_d = INST[11:0];
            3'd3: begin
              sp_d   = sp_dec;
              adrs_d = sp_dec;
              dout_d = {z_q, f_q, level_q, pc_inc};
              rwr_d  = 1'b1;
              pc_d   = INST[11:0];
            end
            3'd4: case (INST[7:6])
              2'd0: bits_d[INST[5:0]] = 1'b0;
              2'd1: bits_d[INST[5:0]] = 1'b1;
              2'd2: f_d = bits_q[INST[5:0]];
              default: f_d = BITSIN[INST[5:0]];
            endcase
            3'd5: begin
              a_d = {3'd0, INST[14:0]};
              z_d = (INST[14:0] == 15'd0);
            end
            3'd6: if (INST[14:12] <= 3'd4) begin
              a_d = alu_r;
              z_d = (alu_r == 18'd0);
            end
            default: case (INST[14:12])
              3'd0: begin adrs_d = imm; state_d = LD1; end
              3'd1: begin adrs_d = imm; dout_d = a_q; rwr_d = 1'b1; end
              3'd2: begin adrs_d = imm; prd_d = 1'b1; state_d = LD1; end
              3'd3: begin adrs_d = imm; dout_d = a_q; pwr_d = 1'b1; end
              3'd4: begin adrs_d = imm; crd_d = 1'b1; state_d = LD1; end
              default: ;
            endcase
          endcase
        end
        LD1: state_d = LD2;
        LD2: begin
          a_d     = DATAIN;
          z_d     = (DATAIN == 18'd0);
          state_d = EXEC;
        end
        RTI1: state_d = RTI2;
        RTI2: begin
          pc_d    = DATAIN[11:0];
          level_d = DATAIN[15:12];
          f_d     = DATAIN[16];
          z_d     = DATAIN[17];
          state_d = EXEC;
        end
        INT: begin
          sp_d    = sp_dec;
          adrs_d  = sp_dec;
          dout_d  = sav_q;
          rwr_d   = 1'b1;
          pc_d    = {8'd0, vec_q};
          state_d = EXEC;
        end
        STOP: ;
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= INIT;
      pc_q    <= 12'd0;
      a_q     <= 18'd0;
      sp_q    <= 18'd0;
      adrs_q  <= 18'd0;
      dout_q  <= 18'd0;
      sav_q   <= 18'd0;
      level_q <= 4'd15;
      vec_q   <= 4'd0;
      z_q     <= 1'b0;
      f_q     <= 1'b0;
      bits_q  <= 64'd0;
      crd_q   <= 1'b0;
      prd_q   <= 1'b0;
      pwr_q   <= 1'b0;
      rwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      sp_q    <= sp_d;
      adrs_q  <= adrs_d;
      dout_q  <= dout_d;
      sav_q   <= sav_d;
      level_q <= level_d;
      vec_q   <= vec_d;
      z_q     <= z_d;
      f_q     <= f_d;
      bits_q  <= bits_d;
      crd_q   <= crd_d;
      prd_q   <= prd_d;
      pwr_q   <= pwr_d;
      rwr_q   <= rwr_d;
    end
  end

endmodule

// File: tb/tb_core_18.sv
// Directed bench for core_18: reset, LEVEL/STOP, interrupt entry, RTI,
// masking, loads, flag bits, branches, CALL and reset during a load.
module tb_core_18;
  logic        CLK = 1'b0;
  logic        RUN;
  logic        RESET;
  logic [17:0] INST;
  logic [3:0]  VECTOR;
  logic [17:0] DATAIN;
  logic [63:0] BITSIN;
  logic [63:0] BITSOUT;
  logic        CONST_RD, PORT_RD, PORT_WR, RAM_WR;
  logic [17:0] DATAOUT, ADRS;
  logic [11:0] PC;

  int checks = 0;
  int failures = 0;

  core_18 dut (
    .CLK(CLK), .RUN(RUN), .RESET(RESET), .INST(INST), .VECTOR(VECTOR),
    .DATAIN(DATAIN), .BITSIN(BITSIN), .BITSOUT(BITSOUT),
    .CONST_RD(CONST_RD), .PORT_RD(PORT_RD), .PORT_WR(PORT_WR), .RAM_WR(RAM_WR),
    .DATAOUT(DATAOUT), .ADRS(ADRS), .PC(PC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [17:0] inst);
    INST = inst;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RUN = 1'b0; INST = 18'd0; VECTOR = 4'd0; DATAIN = 18'd0; BITSIN = 64'd0;
    step(18'd0);
    step(18'd0);
    chk("rst_reset_out", RESET, 1);
    chk("rst_pc", PC, 0);
    chk("rst_state", 64'(dut.state_q), 10'o0002);
    chk("rst_level", dut.level_q, 15);
    chk("rst_adrs", ADRS, 0);
    chk("rst_strobes", {CONST_RD, PORT_RD, PORT_WR, RAM_WR}, 0);
    chk("rst_bitsout", BITSOUT, 0);

    RUN = 1'b1;
    step(18'o000505);
    chk("init_level", dut.level_q, 15);
    chk("init_pc", PC, 0);
    chk("init_state", 64'(dut.state_q), 10'o0001);
    step(18'o000505);
    chk("level_5", dut.level_q, 5);
    chk("level_pc", PC, 1);

    step(18'o000000);
    step(18'o000000);
    step(18'o000100);
    chk("stop_pc", PC, 4);
    chk("stop_state", 64'(dut.state_q), 10'o0020);
    step(18'o000000);
    step(18'o000000);
    step(18'o000000);
    chk("stop_hold_pc", PC, 4);
    chk("stop_hold_state", 64'(dut.state_q), 10'o0020);

    VECTOR = 4'd7;
    step(18'o000000);
    VECTOR = 4'd0;
    chk("irq_level", dut.level_q, 7);
    chk("irq_state", 64'(dut.state_q), 10'o1000);
    step(18'o000000);
    chk("int_state", 64'(dut.state_q), 10'o0001);
    chk("int_pc", PC, 7);
    chk("int_adrs", ADRS, 18'o777777);
    chk("int_dataout", DATAOUT, 18'o050004);
    chk("int_ram_wr", RAM_WR, 1);
    step(18'o000000);
    chk("nop_adrs_hold", ADRS, 18'o777777);
    chk("nop_ram_wr_low", RAM_WR, 0);
    chk("nop_pc", PC, 8);

    step(18'o000400);
    chk("rti1_state", 64'(dut.state_q), 10'o0040);
    chk("rti_adrs", ADRS, 18'o777777);
    step(18'o000000);
    chk("rti2_state", 64'(dut.state_q), 10'o0100);
    DATAIN = 18'o651234;
    step(18'o000000);
    chk("rti_pc", PC, 12'o1234);
    chk("rti_level", dut.level_q, 5);
    chk("rti_zf", {dut.z_q, dut.f_q}, 2'b11);
    chk("rti_state", 64'(dut.state_q), 10'o0001);
    step(18'o000000);
    chk("rti_next_pc", PC, 12'o1235);

    VECTOR = 4'd5;
    step(18'o000000);
    chk("mask_eq_state", 64'(dut.state_q), 10'o0001);
    chk("mask_eq_pc", PC, 12'o1236);
    VECTOR = 4'd3;
    step(18'o000000);
    chk("mask_lt_pc", PC, 12'o1237);
    chk("mask_lt_level", dut.level_q, 5);
    VECTOR = 4'd0;

    step(18'o500000);
    chk("ldi0_z", dut.z_q, 1);
    step(18'o600001);
    chk("add1_z", dut.z_q, 0);
    chk("add1_a", dut.a_q, 1);

    step(18'o720042);
    chk("prd_strobe", PORT_RD, 1);
    chk("prd_adrs", ADRS, 18'o000042);
    chk("prd_ld1", 64'(dut.state_q), 10'o0004);
    DATAIN = 18'o123456;
    step(18'o000000);
    chk("prd_one_cycle", PORT_RD, 0);
    chk("prd_ld2", 64'(dut.state_q), 10'o0010);
    step(18'o000000);
    chk("prd_a", dut.a_q, 18'o123456);
    chk("prd_pc", PC, 12'o1242);

    step(18'o710077);
    chk("st_dataout", DATAOUT, 18'o123456);
    chk("st_ram_wr", RAM_WR, 1);
    chk("st_adrs", ADRS, 18'o000077);

    step(18'o400177);
    chk("bit_set63", BITSOUT, 64'h8000_0000_0000_0000);
    step(18'o400200);
    chk("bit_test0_f", dut.f_q, 0);
    step(18'o400277);
    chk("bit_test63_f", dut.f_q, 1);
    step(18'o400000);
    BITSIN = 64'h20;
    step(18'o400305);
    chk("bitsin5_f", dut.f_q, 1);
    chk("bit_pc", PC, 12'o1250);

    step(18'o200700);
    chk("br_z_not_taken", PC, 12'o1251);
    step(18'o240300);
    chk("br_f_taken", PC, 12'o0300);
    step(18'o100200);
    chk("jmp_pc", PC, 12'o0200);
    step(18'o300500);
    chk("call_pc", PC, 12'o0500);
    chk("call_adrs", ADRS, 18'o777777);
    chk("call_dataout", DATAOUT, 18'o250201);
    chk("call_ram_wr", RAM_WR, 1);

    step(18'o740010);
    chk("crd_strobe", CONST_RD, 1);
    RUN = 1'b0;
    step(18'o000000);
    chk("midload_rst_state", 64'(dut.state_q), 10'o0002);
    chk("midload_rst_pc", PC, 0);
    chk("midload_rst_a", dut.a_q, 0);
    chk("midload_rst_bits", BITSOUT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
